// File: rtl/mips_prog_loader.sv
// Program loader for a small MIPS core: streams a program into instruction memory,
// zero-fills the remainder, pulses core reset, runs the core, then dumps its registers.
module mips_prog_loader #(
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned IMEM_AW     = 8,
  parameter int unsigned PROG_DEPTH  = 19,
  parameter int unsigned REG_CNT     = 8,
  parameter int unsigned REG_W       = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned CRST_CYCLES = 2,
  localparam int unsigned RA_W  = (REG_CNT > 1) ? $clog2(REG_CNT) : 1,
  localparam int unsigned LEN_W = IMEM_AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [LEN_W-1:0]   i_prog_len,
  input  logic [CNT_W-1:0]   i_run_cycles,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [INSTR_W-1:0] i_in_data,
  output logic               o_imem_we,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic [INSTR_W-1:0] o_imem_wdata,
  output logic               o_core_rst,
  output logic               o_core_en,
  output logic [RA_W-1:0]    o_rf_raddr,
  input  logic [REG_W-1:0]   i_rf_rdata,
  output logic               o_dump_valid,
  input  logic               i_dump_ready,
  output logic [RA_W-1:0]    o_dump_idx,
  output logic [REG_W-1:0]   o_dump_data,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned CR_W = (CRST_CYCLES > 1) ? $clog2(CRST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ZFILL, S_CRST, S_RUN, S_DUMP_RD, S_DUMP_OUT, S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_wa, w_wa_nxt, w_wa_inc;
  logic [LEN_W-1:0]   r_len, w_len_nxt, w_len_sat;
  logic [CNT_W-1:0]   r_run, w_run_nxt;
  logic [CNT_W-1:0]   r_rc, w_rc_nxt;
  logic [RA_W-1:0]    r_ri, w_ri_nxt;
  logic [CR_W-1:0]    r_cc, w_cc_nxt;
  logic               r_held, w_held_nxt;
  logic [REG_W-1:0]   r_dump_data, w_dump_data_nxt;

  assign w_wa_inc  = r_wa + LEN_W'(1);
  assign w_len_sat = (i_prog_len > LEN_W'(PROG_DEPTH)) ? LEN_W'(PROG_DEPTH) : i_prog_len;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wa        <= '0;
      r_len       <= '0;
      r_run       <= '0;
      r_rc        <= '0;
      r_ri        <= '0;
      r_cc        <= '0;
      r_held      <= 1'b0;
      r_dump_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wa        <= w_wa_nxt;
      r_len       <= w_len_nxt;
      r_run       <= w_run_nxt;
      r_rc        <= w_rc_nxt;
      r_ri        <= w_ri_nxt;
      r_cc        <= w_cc_nxt;
      r_held      <= w_held_nxt;
      r_dump_data <= w_dump_data_nxt;
    end
  end

  // Next-state and outputs; the first DUMP_OUT cycle forwards read data while it is captured
  always_comb begin
    w_state_nxt     = r_state;
    w_wa_nxt        = r_wa;
    w_len_nxt       = r_len;
    w_run_nxt       = r_run;
    w_rc_nxt        = r_rc;
    w_ri_nxt        = r_ri;
    w_cc_nxt        = r_cc;
    w_held_nxt      = 1'b0;
    w_dump_data_nxt = r_dump_data;
    o_in_ready      = 1'b0;
    o_imem_we       = 1'b0;
    o_imem_addr     = '0;
    o_imem_wdata    = '0;
    o_core_rst      = 1'b1;
    o_core_en       = 1'b0;
    o_rf_raddr      = '0;
    o_dump_valid    = 1'b0;
    o_dump_idx      = '0;
    o_dump_data     = '0;
    o_busy          = (r_state != S_IDLE);
    o_done          = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_len_nxt   = w_len_sat;
          w_run_nxt   = i_run_cycles;
          w_wa_nxt    = '0;
          w_rc_nxt    = '0;
          w_ri_nxt    = '0;
          w_cc_nxt    = '0;
          w_state_nxt = (w_len_sat == LEN_W'(0)) ? S_ZFILL : S_LOAD;
        end
      end
      S_LOAD: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          o_imem_we    = 1'b1;
          o_imem_addr  = r_wa[IMEM_AW-1:0];
          o_imem_wdata = i_in_data;
          w_wa_nxt     = w_wa_inc;
          if (w_wa_inc == r_len)
            w_state_nxt = (r_len == LEN_W'(PROG_DEPTH)) ? S_CRST : S_ZFILL;
        end
      end
      S_ZFILL: begin
        o_imem_we   = 1'b1;
        o_imem_addr = r_wa[IMEM_AW-1:0];
        w_wa_nxt    = w_wa_inc;
        if (r_wa == LEN_W'(PROG_DEPTH - 1)) w_state_nxt = S_CRST;
      end
      S_CRST: begin
        if (r_cc == CR_W'(CRST_CYCLES - 1)) begin
          w_rc_nxt    = '0;
          w_ri_nxt    = '0;
          w_state_nxt = (r_run == CNT_W'(0)) ? S_DUMP_RD : S_RUN;
        end else begin
          w_cc_nxt = r_cc + CR_W'(1);
        end
      end
      S_RUN: begin
        o_core_rst = 1'b0;
        o_core_en  = 1'b1;
        if (r_rc == r_run - CNT_W'(1)) w_state_nxt = S_DUMP_RD;
        else                           w_rc_nxt    = r_rc + CNT_W'(1);
      end
      S_DUMP_RD: begin
        o_core_rst  = 1'b0;
        o_rf_raddr  = r_ri;
        w_state_nxt = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        o_core_rst      = 1'b0;
        o_dump_valid    = 1'b1;
        o_dump_idx      = r_ri;
        o_dump_data     = r_held ? r_dump_data : i_rf_rdata;
        w_dump_data_nxt = o_dump_data;
        w_held_nxt      = 1'b1;
        if (i_dump_ready) begin
          w_held_nxt = 1'b0;
          if (r_ri == RA_W'(REG_CNT - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_ri_nxt    = r_ri + RA_W'(1);
            w_state_nxt = S_DUMP_RD;
          end
        end
      end
      S_DONE: begin
        o_core_rst  = 1'b0;
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Reset silences every output in the same cycle it is asserted
    if (rst) begin
      o_in_ready   = 1'b0;
      o_imem_we    = 1'b0;
      o_imem_addr  = '0;
      o_imem_wdata = '0;
      o_core_rst   = 1'b1;
      o_core_en    = 1'b0;
      o_rf_raddr   = '0;
      o_dump_valid = 1'b0;
      o_dump_idx   = '0;
      o_dump_data  = '0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomized bench for mips_prog_loader: stream/dump agents feed a log that is compared
// against expectations computed from the load/run/dump rules.
module tb_mips_prog_loader;
  localparam int unsigned PD  = 19;
  localparam int unsigned RC  = 8;
  localparam int unsigned CRC = 2;

  typedef struct packed { logic [7:0] a; logic [15:0] d; } wr_t;
  typedef struct packed { logic [2:0] i; logic [15:0] d; } beat_t;

  logic        clk, rst, start;
  logic [8:0]  prog_len;
  logic [15:0] run_cycles;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        core_rst, core_en;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        dump_valid, dump_ready;
  logic [2:0]  dump_idx;
  logic [15:0] dump_data;
  logic        busy, done;

  mips_prog_loader #(
    .INSTR_W(16), .IMEM_AW(8), .PROG_DEPTH(PD), .REG_CNT(RC),
    .REG_W(16), .CNT_W(16), .CRST_CYCLES(CRC)
  ) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_prog_len(prog_len),
    .i_run_cycles(run_cycles), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .o_imem_we(imem_we), .o_imem_addr(imem_addr),
    .o_imem_wdata(imem_wdata), .o_core_rst(core_rst), .o_core_en(core_en),
    .o_rf_raddr(rf_raddr), .i_rf_rdata(rf_rdata), .o_dump_valid(dump_valid),
    .i_dump_ready(dump_ready), .o_dump_idx(dump_idx), .o_dump_data(dump_data),
    .o_busy(busy), .o_done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file with one-cycle read latency
  logic [15:0] regs [RC];
  always @(posedge clk) rf_rdata <= regs[rf_raddr];

  int n_cmp = 0;
  int n_mis = 0;

  // Stimulus controls written by the sequence
  logic [15:0] tx_words [64];
  int tx_len = 0, gap_pct = 0, stall = 0;

  // Agent state and logs
  int     tx_ptr = 0, wcnt = 0;
  logic   hs_in = 1'b0, hs_dump = 1'b0, prev_dv = 1'b0, in_beat = 1'b0;
  logic [2:0]  f_idx;
  logic [15:0] f_data;
  wr_t    wr_q[$];
  beat_t  beat_q[$];
  int n_en = 0, n_enbad = 0, n_done = 0, n_crst = 0, n_badwr = 0, n_unst = 0;

  // Drive stream/ready on the falling edge, then sample everything just before the rising edge
  always @(negedge clk) begin
    if (hs_in) tx_ptr++;
    if (tx_ptr < tx_len && $urandom_range(99) >= gap_pct) begin
      in_valid = 1'b1;
      in_data  = tx_words[tx_ptr];
    end else begin
      in_valid = 1'b0;
      in_data  = 16'($urandom);
    end
    if (hs_dump || !prev_dv) begin
      dump_ready = 1'b0;
      wcnt = 0;
    end else if (!dump_ready) begin
      if (wcnt >= stall) dump_ready = 1'b1;
      else wcnt++;
    end
    #3;
    if (start && !busy) begin
      tx_ptr = 0;
      wcnt = 0;
    end
    hs_in   = in_valid && in_ready;
    hs_dump = dump_valid && dump_ready;
    prev_dv = dump_valid;
    if (imem_we) begin
      wr_q.push_back({imem_addr, imem_wdata});
      if (in_ready && (!in_valid || imem_wdata !== in_data)) n_badwr++;
    end
    if (core_en) begin
      n_en++;
      if (core_rst) n_enbad++;
    end
    if (busy && core_rst && !in_ready && !imem_we) n_crst++;
    if (done) n_done++;
    if (dump_valid) begin
      if (!in_beat) begin
        in_beat = 1'b1;
        f_idx = dump_idx;
        f_data = dump_data;
      end else if (dump_idx !== f_idx || dump_data !== f_data) begin
        n_unst++;
      end
      if (dump_ready) begin
        beat_q.push_back({dump_idx, dump_data});
        in_beat = 1'b0;
      end
    end else begin
      in_beat = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int b_wr, b_beat, b_en, b_done, b_crst, b_badwr, b_unst, b_enbad;
  int cur_len, cur_run;

  task automatic launch(input int len, input int run, input int gap, input int stl, input int nw);
    @(negedge clk);
    for (int i = 0; i < 64; i++) tx_words[i] = 16'($urandom);
    tx_len = nw; gap_pct = gap; stall = stl;
    b_wr = wr_q.size(); b_beat = beat_q.size(); b_en = n_en; b_done = n_done;
    b_crst = n_crst; b_badwr = n_badwr; b_unst = n_unst; b_enbad = n_enbad;
    cur_len = len; cur_run = run;
    start = 1'b1; prog_len = 9'(len); run_cycles = 16'(run);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (n_done == b_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 64'(n_done != b_done), 64'(1));
    repeat (4) @(negedge clk);
  endtask

  // Expected image: first min(len,PD) words from the stream, zeros after; one beat per register
  task automatic check_seq(input string tag);
    int eff = (cur_len > int'(PD)) ? int'(PD) : cur_len;
    int nwr = wr_q.size() - b_wr;
    int nbt = beat_q.size() - b_beat;
    check({tag, "_nwrites"}, 64'(nwr), 64'(PD));
    for (int a = 0; a < int'(PD) && a < nwr; a++) begin
      wr_t w = wr_q[b_wr + a];
      logic [15:0] e = (a < eff) ? tx_words[a] : 16'h0000;
      check($sformatf("%s_waddr%0d", tag, a), 64'(w.a), 64'(a));
      check($sformatf("%s_wdata%0d", tag, a), 64'(w.d), 64'(e));
    end
    check({tag, "_crst_cycles"}, 64'(n_crst - b_crst), 64'(CRC));
    check({tag, "_en_cycles"}, 64'(n_en - b_en), 64'(cur_run));
    check({tag, "_en_with_rst"}, 64'(n_enbad - b_enbad), 64'(0));
    check({tag, "_nbeats"}, 64'(nbt), 64'(RC));
    for (int i = 0; i < int'(RC) && i < nbt; i++) begin
      beat_t b = beat_q[b_beat + i];
      check($sformatf("%s_idx%0d", tag, i), 64'(b.i), 64'(i));
      check($sformatf("%s_reg%0d", tag, i), 64'(b.d), 64'(regs[i]));
    end
    check({tag, "_done_pulses"}, 64'(n_done - b_done), 64'(1));
    check({tag, "_bad_writes"}, 64'(n_badwr - b_badwr), 64'(0));
    check({tag, "_dump_unstable"}, 64'(n_unst - b_unst), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_imem_we"}, 64'(imem_we), 64'(0));
    check({tag, "_imem_addr"}, 64'(imem_addr), 64'(0));
    check({tag, "_core_rst"}, 64'(core_rst), 64'(1));
    check({tag, "_core_en"}, 64'(core_en), 64'(0));
    check({tag, "_dump_valid"}, 64'(dump_valid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
  endtask

  initial begin
    int k, nw0, nb0, nd0;
    rst = 1'b1; start = 1'b0; prog_len = '0; run_cycles = '0;
    for (int i = 0; i < int'(RC); i++) regs[i] = 16'($urandom);
    regs[3] = 16'h0012;

    repeat (3) @(negedge clk);
    #3;
    check_reset_outputs("reset");
    check("reset_rf_raddr", 64'(rf_raddr), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back load of 9 words, 100 run cycles
    launch(9, 100, 0, 0, 9);
    wait_done("A", 2000);
    check_seq("A");

    // Gappy stream of 3 words, slow dump; start pulsed while busy must be ignored
    launch(3, int'($urandom_range(5, 40)), 50, 4, 3);
    repeat (8) @(negedge clk);
    start = 1'b1; prog_len = 9'd1; run_cycles = 16'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("B", 2000);
    check_seq("B");

    // Oversized program saturates; zero run cycles still dumps
    launch(40, 0, 20, 1, 40);
    wait_done("C", 2000);
    check_seq("C");

    // Randomized sequences, including an empty program
    for (int t = 0; t < 3; t++) begin
      int len = (t == 0) ? 0 : int'($urandom_range(1, 25));
      launch(len, int'($urandom_range(0, 60)), int'($urandom_range(0, 60)),
             int'($urandom_range(0, 3)), len);
      wait_done($sformatf("D%0d", t), 3000);
      check_seq($sformatf("D%0d", t));
    end

    // Reset during LOAD once four words are written
    launch(10, 20, 0, 0, 10);
    k = 0;
    while ((wr_q.size() - b_wr) < 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("E_reached_wa4", 64'(wr_q.size() - b_wr), 64'(4));
    rst = 1'b1;
    #3;
    check("E_rst_cycle_we", 64'(imem_we), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #3;
    check_reset_outputs("E_after");
    check("E_no_more_writes", 64'(wr_q.size() - b_wr), 64'(4));
    check("E_no_done", 64'(n_done - b_done), 64'(0));

    // Reset during a stalled dump beat
    launch(0, 0, 0, 30, 0);
    k = 0;
    while (!dump_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("F_dump_reached", 64'(dump_valid), 64'(1));
    nb0 = beat_q.size(); nw0 = wr_q.size(); nd0 = n_done;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #3;
    check_reset_outputs("F_after");
    check("F_no_beats", 64'(beat_q.size() - nb0), 64'(0));
    check("F_no_writes", 64'(wr_q.size() - nw0), 64'(0));
    check("F_no_done", 64'(n_done - nd0), 64'(0));

    // Clean sequence after the aborts
    launch(5, 10, 10, 2, 5);
    wait_done("G", 2000);
    check_seq("G");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of test, required finish before 400000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_prog_loader.md
MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 Parameter INSTR_W, 16, instruction word width.
REQ-002 Parameter IMEM_AW, 8, instruction memory address width.
REQ-003 Parameter PROG_DEPTH, 19, words written per load (program plus zero fill); PROG_DEPTH <= 2**IMEM_AW.
REQ-004 Parameter REG_CNT, 8, register file entries to dump; RA_W = clog2(REG_CNT).
REQ-005 Parameter REG_W, 16, register width.
REQ-006 Parameter CNT_W, 16, run-cycle counter width.
REQ-007 Parameter CRST_CYCLES, 2, core reset pulse length after load, >= 1.
REQ-008 The block SHALL use one clock; reset is synchronous and active-high, with ports clk (input, 1, clock) and rst (input, 1, synchronous active-high reset).
REQ-009 start  in  1  begin load/run/dump sequence, sampled in IDLE only.
REQ-010 prog_len  in  IMEM_AW+1  program words to accept from stream, sampled with start.
REQ-011 run_cycles  in  CNT_W  core enable cycles, sampled with start.
REQ-012 in_valid / in_ready / in_data  in / out / in  1 / 1 / INSTR_W  program stream, transfer when valid and ready.
REQ-013 imem_we / imem_addr / imem_wdata  out  1 / IMEM_AW / INSTR_W  instruction memory write port.
REQ-014 core_rst  out  1  core reset; core_en  out  1  core clock enable.
REQ-015 rf_raddr  out  RA_W; rf_rdata  in  REG_W  register file read port, data valid one cycle after address.
REQ-016 dump_valid / dump_ready / dump_idx / dump_data  out / in / out / out  1 / 1 / RA_W / REG_W  register dump stream.
REQ-017 busy  out  1  high outside IDLE; done  out  1  one-cycle pulse at sequence end.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, ZFILL, CRST, RUN, DUMP_RD, DUMP_OUT, DONE.
REQ-019 IDLE: start=1 -> latch len = min(prog_len, PROG_DEPTH) and run_cycles, clear word counter wa=0; go LOAD if len>0, else ZFILL.
REQ-020 LOAD: in_ready=1; each transfer drives imem_we=1, imem_addr=wa, imem_wdata=in_data in the same cycle, then wa++; after transfer number len go ZFILL, or CRST if len==PROG_DEPTH.
REQ-021 in_ready SHALL be 0 in every state except LOAD; in_valid without in_ready SHALL be ignored.
REQ-022 ZFILL: one write per cycle of imem_wdata=0 at wa, wa++, until wa==PROG_DEPTH, then CRST.
REQ-023 CRST: core_rst=1 for exactly CRST_CYCLES cycles, then RUN with cycle counter rc=0.
REQ-024 RUN: core_rst=0, core_en=1; exactly run_cycles cycles with core_en=1, then DUMP_RD with ri=0; run_cycles=0 SHALL go directly to DUMP_RD with zero enabled cycles.
REQ-025 core_rst SHALL be 1 in IDLE, LOAD, ZFILL and CRST, and 0 in RUN, DUMP_RD, DUMP_OUT and DONE; core_en SHALL be 1 only in RUN, which freezes the core during the dump.
REQ-026 DUMP_RD: drive rf_raddr=ri for one cycle, then DUMP_OUT.
REQ-027 DUMP_OUT: dump_valid=1, dump_idx=ri, dump_data=rf_rdata captured in a register; hold all three stable until dump_ready=1.
REQ-028 On handshake: if ri==REG_CNT-1 go DONE, else ri++ and go DUMP_RD.
REQ-029 DONE: done=1 for one cycle, then IDLE.
REQ-030 start SHALL be ignored outside IDLE.
REQ-031 wa SHALL never exceed PROG_DEPTH-1 on a write, and prog_len > PROG_DEPTH SHALL saturate to PROG_DEPTH.
REQ-032 The rc counter SHALL be CNT_W bits wide, and run_cycles = 2**CNT_W-1 SHALL complete without wrap error.

Reset
REQ-033 rst=1 at any clock edge SHALL force IDLE with wa=ri=rc=0 and all pending dump data discarded.
REQ-034 rst=1 SHALL drive outputs imem_we=0, in_ready=0, core_rst=1, core_en=0, dump_valid=0, busy=0, done=0, and addresses and data to 0.
REQ-035 Reset asserted mid-LOAD or mid-DUMP SHALL abort the sequence with no further imem writes or dump beats, and in_ready=0 from the next cycle.

Verification
REQ-036 Defaults, prog_len=9, 9 words streamed back-to-back, run_cycles=100 -> imem addresses 0..8 hold the data, 9..18 hold 0; core_rst low for exactly 100 cycles with core_en=1; 8 dump beats idx 0..7; done pulses once.
REQ-037 Stream with in_valid gaps and prog_len=3 -> exactly 3 writes at addresses 0..2, then zero writes at 3..18, with no write on cycles where in_valid=0.
REQ-038 dump_ready held low 5 cycles per beat -> each beat's dump_idx and dump_data stay stable until its handshake; register values match a preloaded file such as R3=16'h0012.
REQ-039 prog_len=40 (above PROG_DEPTH) -> exactly 19 writes, then direct to CRST; run_cycles=0 -> zero core_en cycles, dump still occurs.
REQ-040 rst pulsed during LOAD at wa=4 -> IDLE next cycle, no further writes, core_rst=1; start re-pulsed while busy -> ignored.
